traffic_conflict_monitor: RTL and testbench



---
 rtl/traffic_conflict_monitor.sv | 189 ++++++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_conflict_monitor.sv
// Lamp safety monitor: passes lamps through one clk late; on a violation it latches a cause and flashes both reds until cleared.
// No backpressure. Define TLC_MON_MIN_GREEN_EN to add the short-green check (code 6, parameter MIN_GRN_TICKS).
module traffic_conflict_monitor #(
  parameter int MIN_YEL_TICKS = 1,
  parameter int DARK_TICKS    = 2,
  parameter int FLASH_TICKS   = 4,
  parameter int CNT_W         = 4
`ifdef TLC_MON_MIN_GREEN_EN
  ,
  parameter int MIN_GRN_TICKS = 5
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       R_a,
  input  logic       Y_a,
  input  logic       G_a,
  input  logic       R_b,
  input  logic       Y_b,
  input  logic       G_b,
  input  logic       clear_fault,
  output logic       R_a_o,
  output logic       Y_a_o,
  output logic       G_a_o,
  output logic       R_b_o,
  output logic       Y_b_o,
  output logic       G_b_o,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] mon_state
);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] YEL_LIM    = CNT_W'(MIN_YEL_TICKS);
  localparam logic [CNT_W-1:0] DARK_LIM   = CNT_W'(DARK_TICKS);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);
`ifdef TLC_MON_MIN_GREEN_EN
  localparam logic [CNT_W-1:0] GRN_LIM    = CNT_W'(MIN_GRN_TICKS);
`endif

  // Per-head lamp vectors are {R,Y,G}; index 0 is head A, 1 is head B.
  logic [2:0]       cur_q      [2];
  logic [1:0]       prev_q     [2];
  logic             tick_q;
  logic [CNT_W-1:0] yel_cnt_q  [2];
  logic [CNT_W-1:0] dark_cnt_q [2];
`ifdef TLC_MON_MIN_GREEN_EN
  logic [CNT_W-1:0] grn_cnt_q  [2];
`endif

  state_e           state_q, state_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic             flash_q, flash_d;
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [6:1]       fired;
  logic [2:0]       viol_code;
  logic [2:0]       drv_a, drv_b;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic on, input logic adv);
    if (!on)
      return '0;
    else if (adv && (c != '1))
      return c + CNT_W'(1);
    else
      return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q       <= 1'b0;
      state_q      <= ST_ARM;
      fault_code_q <= 3'd0;
      flash_q      <= 1'b0;
      flash_cnt_q  <= '0;
      for (int h = 0; h < 2; h++) begin
        cur_q[h]      <= 3'b000;
        prev_q[h]     <= 2'b00;
        yel_cnt_q[h]  <= '0;
        dark_cnt_q[h] <= '0;
`ifdef TLC_MON_MIN_GREEN_EN
        grn_cnt_q[h]  <= '0;
`endif
      end
    end else begin
      tick_q       <= tick;
      cur_q[0]     <= {R_a, Y_a, G_a};
      cur_q[1]     <= {R_b, Y_b, G_b};
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      flash_q      <= flash_d;
      flash_cnt_q  <= flash_cnt_d;
      for (int h = 0; h < 2; h++) begin
        prev_q[h]     <= cur_q[h][1:0];
        yel_cnt_q[h]  <= cnt_next(yel_cnt_q[h], cur_q[h][1], tick_q);
        dark_cnt_q[h] <= cnt_next(dark_cnt_q[h], cur_q[h] == 3'b000, tick_q);
`ifdef TLC_MON_MIN_GREEN_EN
        grn_cnt_q[h]  <= cnt_next(grn_cnt_q[h], cur_q[h][0], tick_q);
`endif
      end
    end
  end

  // Each check sets its own bit; the lowest set code becomes the cause.
  always_comb begin
    fired = '0;
    if ((|cur_q[0][1:0]) && (|cur_q[1][1:0]))
      fired[1] = 1'b1;
    for (int h = 0; h < 2; h++) begin
      if ($countones(cur_q[h]) > 1)
        fired[2] = 1'b1;
      if ((cur_q[h] == 3'b000) && (dark_cnt_q[h] == DARK_LIM))
        fired[3] = 1'b1;
      if (prev_q[h][1] && !cur_q[h][1] && (yel_cnt_q[h] < YEL_LIM))
        fired[4] = 1'b1;
      if (prev_q[h][0] && cur_q[h][2])
        fired[5] = 1'b1;
`ifdef TLC_MON_MIN_GREEN_EN
      if (prev_q[h][0] && !cur_q[h][0] && (grn_cnt_q[h] < GRN_LIM))
        fired[6] = 1'b1;
`endif
    end
    viol_code = 3'd0;
    for (int i = 6; i >= 1; i--)
      if (fired[i])
        viol_code = 3'(i);
  end

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    flash_d      = flash_q;
    flash_cnt_d  = flash_cnt_q;
    drv_a        = 3'b100;
    drv_b        = 3'b100;
    case (state_q)
      ST_ARM: begin
        if ((cur_q[0] == 3'b001) && (cur_q[1] == 3'b100))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        drv_a = cur_q[0];
        drv_b = cur_q[1];
        if (viol_code != 3'd0) begin
          state_d      = ST_FAULT;
          fault_code_d = viol_code;
          flash_d      = 1'b1;
          flash_cnt_d  = '0;
        end
      end
      ST_FAULT: begin
        drv_a = {flash_q, 2'b00};
        drv_b = {flash_q, 2'b00};
        if (clear_fault) begin
          state_d      = ST_ARM;
          fault_code_d = 3'd0;
          flash_d      = 1'b0;
          flash_cnt_d  = '0;
        end else if (tick_q) begin
          if (flash_cnt_q == FLASH_LAST) begin
            flash_d     = !flash_q;
            flash_cnt_d = '0;
          end else begin
            flash_cnt_d = flash_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d      = ST_ARM;
        fault_code_d = 3'd0;
        flash_d      = 1'b0;
        flash_cnt_d  = '0;
      end
    endcase
  end

  assign {R_a_o, Y_a_o, G_a_o} = drv_a;
  assign {R_b_o, Y_b_o, G_b_o} = drv_b;
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign mon_state  = state_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: a sample-history reference model predicts every cycle's outputs.
module tb_traffic_conflict_monitor;

  localparam int MIN_YEL = 1;
  localparam int DARK    = 2;
  localparam int FLASH   = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;
`ifdef TLC_MON_MIN_GREEN_EN
  localparam int MIN_GRN = 5;
`endif

  // Lamp patterns {R_a,Y_a,G_a,R_b,Y_b,G_b}
  localparam logic [5:0] AG = 6'b001_100;
  localparam logic [5:0] AY = 6'b010_100;
  localparam logic [5:0] BG = 6'b100_001;
  localparam logic [5:0] BY = 6'b100_010;
  localparam logic [5:0] RR = 6'b100_100;

  logic       clk = 1'b0;
  logic       reset, tick, clear_fault;
  logic       R_a, Y_a, G_a, R_b, Y_b, G_b;
  logic       R_a_o, Y_a_o, G_a_o, R_b_o, Y_b_o, G_b_o;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] mon_state;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(
    .MIN_YEL_TICKS(MIN_YEL),
    .DARK_TICKS   (DARK),
    .FLASH_TICKS  (FLASH),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .R_a        (R_a),
    .Y_a        (Y_a),
    .G_a        (G_a),
    .R_b        (R_b),
    .Y_b        (Y_b),
    .G_b        (G_b),
    .clear_fault(clear_fault),
    .R_a_o      (R_a_o),
    .Y_a_o      (Y_a_o),
    .G_a_o      (G_a_o),
    .R_b_o      (R_b_o),
    .Y_b_o      (Y_b_o),
    .G_b_o      (G_b_o),
    .fault      (fault),
    .fault_code (fault_code),
    .mon_state  (mon_state)
  );

  typedef struct packed {
    logic [5:0] drv;
    logic       flt;
    logic [2:0] code;
    logic [1:0] st;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [5:0] h_l[$];
  bit         h_t[$];
  int         rst_idx  = 0;
  int         m_mode   = 0;   // 0 arm, 1 run, 2 fault
  int         m_code   = 0;
  int         m_fstart = 0;
  int         checks   = 0;
  int         errors   = 0;
  logic [5:0] pat [4] = '{AG, AY, BG, BY};

  function automatic logic [2:0] head(input logic [5:0] l, input int h);
    return (h == 0) ? l[5:3] : l[2:0];
  endfunction

  // Ticks seen during the unbroken run of a lamp condition ending at sample idx.
  function automatic int run_ticks(input int h, input int kind, input int idx);
    int s;
    logic [2:0] v;
    bit on;
    s = 0;
    for (int j = idx; j >= rst_idx; j--) begin
      v  = head(h_l[j], h);
      on = (kind == 0) ? v[1] : (kind == 1) ? (v == 3'b000) : v[0];
      if (!on) break;
      s += int'(h_t[j]);
    end
    return (s > SAT) ? SAT : s;
  endfunction

  function automatic int violation(input int k);
    logic [2:0] c [2];
    logic [2:0] p [2];
    bit   [7:0] hit;
    hit = '0;
    for (int h = 0; h < 2; h++) begin
      c[h] = head(h_l[k], h);
      p[h] = head(h_l[k-1], h);
    end
    if ((c[0][1] || c[0][0]) && (c[1][1] || c[1][0])) hit[1] = 1'b1;
    for (int h = 0; h < 2; h++) begin
      if ($countones(c[h]) > 1) hit[2] = 1'b1;
      if (c[h] == 3'b000 && run_ticks(h, 1, k - 1) == DARK) hit[3] = 1'b1;
      if (p[h][1] && !c[h][1] && run_ticks(h, 0, k - 1) < MIN_YEL) hit[4] = 1'b1;
      if (p[h][0] && c[h][2]) hit[5] = 1'b1;
`ifdef TLC_MON_MIN_GREEN_EN
      if (p[h][0] && !c[h][0] && run_ticks(h, 2, k - 1) < MIN_GRN) hit[6] = 1'b1;
`endif
    end
    for (int i = 1; i < 8; i++)
      if (hit[i]) return i;
    return 0;
  endfunction

  // Predict the outputs visible after the clock edge that samples these inputs.
  task automatic model_edge(input logic [5:0] l, input bit t, input bit clr, input bit rst_n);
    exp_t e;
    int   k, n, ticks, v;
    if (!rst_n) begin
      h_l.push_back(6'b0);
      h_t.push_back(1'b0);
      rst_idx = h_l.size() - 1;
      m_mode  = 0;
      m_code  = 0;
    end else begin
      k = h_l.size() - 1;
      case (m_mode)
        0: if (h_l[k] == AG) m_mode = 1;
        1: begin
          v = violation(k);
          if (v != 0) begin
            m_mode   = 2;
            m_code   = v;
            m_fstart = k + 1;
          end
        end
        default: if (clr) begin
          m_mode = 0;
          m_code = 0;
        end
      endcase
      h_l.push_back(l);
      h_t.push_back(t);
    end
    n      = h_l.size() - 1;
    e.st   = m_mode[1:0];
    e.flt  = (m_mode == 2);
    e.code = m_code[2:0];
    if (m_mode == 1) begin
      e.drv = h_l[n];
    end else if (m_mode == 2) begin
      ticks = 0;
      for (int j = m_fstart; j < n; j++) ticks += int'(h_t[j]);
      e.drv = (((ticks / FLASH) % 2) == 0) ? RR : 6'b000_000;
    end else begin
      e.drv = RR;
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [5:0] l, input bit t, input bit clr, input bit rst_n);
    @(negedge clk);
    {R_a, Y_a, G_a, R_b, Y_b, G_b} = l;
    tick        = t;
    clear_fault = clr;
    reset       = rst_n;
    model_edge(l, t, clr, rst_n);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("drivers", {2'b00, R_a_o, Y_a_o, G_a_o, R_b_o, Y_b_o, G_b_o}, {2'b00, mon_e.drv});
      check("fault", {7'd0, fault}, {7'd0, mon_e.flt});
      check("fault_code", {5'd0, fault_code}, {5'd0, mon_e.code});
      check("mon_state", {6'd0, mon_state}, {6'd0, mon_e.st});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int       ph, left;
    logic [5:0] l;
    bit       t, c, r;
    reset = 1'b0; tick = 1'b0; clear_fault = 1'b0;
    {R_a, Y_a, G_a, R_b, Y_b, G_b} = 6'b0;

    cyc(RR, 1, 1, 0);                       // reset wins over clear_fault
    cyc(RR, 1, 0, 0);
    for (int rep = 0; rep < 3; rep++) begin // normal controller cycle
      repeat (6) cyc(AG, 1, 0, 1);
      cyc(AY, 1, 0, 1);
      repeat (5) cyc(BG, 1, 0, 1);
      cyc(BY, 1, 0, 1);
    end
    cyc(AG, 1, 1, 1);                       // clear in RUN is ignored
    cyc(6'b001_001, 1, 0, 1);               // conflict
    repeat (12) cyc(AG, 1, 0, 1);
    cyc(AG, 1, 1, 1);
    repeat (3) cyc(AG, 1, 0, 1);
    repeat (2) cyc(RR, 1, 0, 1);            // skip yellow on A
    repeat (3) cyc(RR, 1, 0, 1);
    cyc(RR, 1, 1, 1);
    repeat (3) cyc(RR, 1, 0, 1);
    repeat (3) cyc(AG, 1, 0, 1);
    repeat (5) cyc(6'b001_000, 1, 0, 1);    // head B dark with ticks
    cyc(AG, 1, 1, 1);
    repeat (3) cyc(AG, 1, 0, 1);
    repeat (10) cyc(6'b001_000, 0, 0, 1);   // dark but time frozen
    repeat (3) cyc(AG, 1, 0, 1);
    cyc(6'b011_001, 1, 0, 1);               // conflict and multi together
    repeat (3) cyc(6'b101_100, 1, 0, 1);
    repeat (2) cyc(AG, 1, 0, 1);
    cyc(AG, 1, 0, 0);                       // reset mid-fault
    repeat (3) cyc(RR, 1, 0, 1);
    repeat (3) cyc(AG, 1, 0, 1);            // short green
    cyc(AY, 1, 0, 1);
    repeat (3) cyc(BG, 1, 0, 1);
    cyc(BG, 1, 1, 1);

    ph = 0; left = 0;
    for (int i = 0; i < 500; i++) begin
      if (left == 0) begin
        ph   = (ph + 1) % 4;
        left = $urandom_range(1, 7);
      end
      left--;
      l = pat[ph];
      if ($urandom_range(0, 9) == 0) l = 6'($urandom());
      t = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 149) != 0);
      cyc(l, t, c, r);
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
